result_drain: RTL and testbench

- Reads a rows x cols result matrix from the unified buffer's single read port and streams it to the host over a valid/ready interface, in row-major order.
- It is the reader counterpart of the buffer write path that the systolic array fills. It sits between the unified buffer and the host/testbench output port of tpu.
- It handles the buffer's 1-cycle read latency and host backpressure with a 2-entry output FIFO.

---
 rtl/result_drain.sv | 161 ++++++++++++++++
 tb/tb_result_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Streams a rows x cols matrix from the unified buffer to the host in row-major order.
// Optional RESULT_RELU_EN macro clamps negative elements to zero at the output.
module result_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_row_end,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    // Handshake: an element transfers on a cycle where out_valid && out_ready; once
    // out_valid rises, it and the qualified data/tags hold until that transfer.

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [DIM_WIDTH-1:0]  cfg_rows;
    logic [DIM_WIDTH-1:0]  cfg_cols;
    logic [DIM_WIDTH-1:0]  r;
    logic [DIM_WIDTH-1:0]  c;

    logic                  inflight;
    logic                  inflight_row_end;
    logic                  inflight_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_row_end [2];
    logic                  fifo_last [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  pop;
    logic                  issue;
    logic                  col_end;
    logic                  row_last;
    logic [1:0]            credit;
    logic [DATA_WIDTH-1:0] head;

    // Credit counts FIFO entries plus the read whose data arrives next cycle.
    assign credit   = count + {1'b0, inflight};
    assign pop      = out_valid && out_ready;
    assign issue    = (state == RUN) && ((credit < 2'd2) || ((credit == 2'd2) && pop));
    assign col_end  = (c == cfg_cols - DIM_ONE);
    assign row_last = (r == cfg_rows - DIM_ONE);

    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? row_addr + {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, c} : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_stride <= '0;
            cfg_rows   <= '0;
            cfg_cols   <= '0;
            row_addr   <= '0;
            r          <= '0;
            c          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_stride <= row_stride;
                        cfg_rows   <= num_rows;
                        cfg_cols   <= num_cols;
                        row_addr   <= base_addr;
                        r          <= '0;
                        c          <= '0;
                        if (num_rows == '0 || num_cols == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (col_end) begin
                            c        <= '0;
                            r        <= r + DIM_ONE;
                            row_addr <= row_addr + cfg_stride;
                            if (row_last) state <= FLUSH;
                        end else begin
                            c <= c + DIM_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight         <= 1'b0;
            inflight_row_end <= 1'b0;
            inflight_last    <= 1'b0;
            count            <= 2'd0;
            rd_ptr           <= 1'b0;
            wr_ptr           <= 1'b0;
        end else begin
            inflight         <= issue;
            inflight_row_end <= issue && col_end;
            inflight_last    <= issue && col_end && row_last;
            if (inflight) begin
                fifo_data[wr_ptr]    <= mem_rd_data;
                fifo_row_end[wr_ptr] <= inflight_row_end;
                fifo_last[wr_ptr]    <= inflight_last;
                wr_ptr               <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid   = (count != 2'd0);
    assign head        = fifo_data[rd_ptr];
    assign out_row_end = out_valid && fifo_row_end[rd_ptr];
    assign out_last    = out_valid && fifo_last[rd_ptr];
`ifdef RESULT_RELU_EN
    assign out_data = (out_valid && !head[DATA_WIDTH-1]) ? head : '0;
`else
    assign out_data = out_valid ? head : '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: buffer responder, queue-based reference model and
// handshake monitor; honours RESULT_RELU_EN when compiled with it.
module tb_result_drain;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  row_stride;
  logic [3:0]  num_rows;
  logic [3:0]  num_cols;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_row_end;
  logic        out_last;
  logic        busy;
  logic        done;

  result_drain #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DIM_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .num_rows(num_rows), .num_cols(num_cols),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_end(out_row_end), .out_last(out_last), .busy(busy), .done(done)
  );

`ifdef RESULT_RELU_EN
  localparam logic [15:0] RELU_EXP0 = 16'h0000;
`else
  localparam logic [15:0] RELU_EXP0 = 16'hFFF0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // buffer with one-cycle read latency; junk when not reading
  logic [15:0] mem_model [256];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem_model[mem_rd_addr] : 16'($urandom);

  // host readiness patterns: 0 always, 1 = 1,0,0,1 repeating, 2 random, 3 never
  int         ready_mode = 0;
  logic [3:0] ready_pat = 4'b1001;
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ready_pat[ph]; ph = (ph + 1) % 4; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // reference model and scoreboard
  logic [17:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [15:0] got_q[$];

  function automatic logic [15:0] model_val(input logic [15:0] v);
`ifdef RESULT_RELU_EN
    return ($signed(v) < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic build_model(input logic [7:0] b, input logic [7:0] s,
                             input logic [3:0] nr, input logic [3:0] nc);
    exp_q.delete();
    exp_addr_q.delete();
    for (int ri = 0; ri < int'(nr); ri++) begin
      for (int ci = 0; ci < int'(nc); ci++) begin
        logic [7:0] a;
        logic       re;
        logic       la;
        a  = 8'(int'(b) + ri * int'(s) + ci);
        re = (ci == int'(nc) - 1);
        la = re && (ri == int'(nr) - 1);
        exp_addr_q.push_back(a);
        exp_q.push_back({la, re, model_val(mem_model[a])});
      end
    end
  endtask

  bit          sb_en = 0;
  int          issued, popped, hs_count, done_count, valid_seen;
  int          done_cyc, first_rd_cyc, first_hs_cyc, last_hs_cyc;
  logic        stall_prev = 1'b0;
  logic [17:0] prev_head;

  task automatic clear_sb();
    issued = 0; popped = 0; hs_count = 0; done_count = 0; valid_seen = 0;
    done_cyc = -1; first_rd_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    got_q.delete();
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_head", 32'({out_last, out_row_end, out_data}), 32'(prev_head));
      end
      if (mem_rd_en) begin
        check("credit", 32'((issued - popped < 2) || (out_valid && out_ready)), 32'd1);
        check("read_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr_q.pop_front()));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        issued++;
      end
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        check("elem_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("elem", 32'({out_last, out_row_end, out_data}), 32'(exp_q.pop_front()));
        got_q.push_back(out_data);
        popped++;
        hs_count++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_head  = {out_last, out_row_end, out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic launch(input logic [7:0] b, input logic [7:0] s,
                        input logic [3:0] nr, input logic [3:0] nc, output int k);
    @(posedge clk);
    #1;
    base_addr = b; row_stride = s; num_rows = nr; num_cols = nc; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input logic [7:0] b, input logic [7:0] s,
                       input logic [3:0] nr, input logic [3:0] nc,
                       input bit poke, output int k);
    bit seen;
    build_model(b, s, nr, nc);
    clear_sb();
    sb_en = 1;
    launch(b, s, nr, nc, k);
    check("busy_after_start", 32'(busy), 32'(nr != 0 && nc != 0));
    if (poke) begin
      base_addr = ~b; row_stride = s + 8'd1; num_rows = 4'd1; num_cols = 4'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("all_elems", 32'(exp_q.size()), 32'd0);
    check("all_reads", 32'(exp_addr_q.size()), 32'd0);
    check("hs_count", 32'(hs_count), 32'(int'(nr) * int'(nc)));
    check("done_once", 32'(done_count), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0; start = 1'b0;
    base_addr = '0; row_stride = '0; num_rows = '0; num_cols = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done}), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_outs", 32'({mem_rd_en, out_valid, busy, done}), 32'd0);

    // 2x3, host always ready: exact pipeline timing
    ready_mode = 0;
    drain(8'h10, 8'd4, 4'd2, 4'd3, 0, k);
    check("t1_first_rd", 32'(first_rd_cyc), 32'(k));
    check("t1_first_out", 32'(first_hs_cyc), 32'(k + 2));
    check("t1_last_out", 32'(last_hs_cyc), 32'(k + 7));
    check("t1_done_cyc", 32'(done_cyc), 32'(k + 8));

    // same matrix under 1,0,0,1 backpressure
    ready_mode = 1;
    drain(8'h10, 8'd4, 4'd2, 4'd3, 0, k);

    // empty matrix: no reads, immediate done
    ready_mode = 0;
    drain(8'h10, 8'd4, 4'd0, 4'd5, 0, k);
    check("t3_no_reads", 32'(issued), 32'd0);
    check("t3_no_valid", 32'(valid_seen), 32'd0);
    check("t3_done_cyc", 32'(done_cyc), 32'(k));

    // address wrap
    drain(8'hFE, 8'd1, 4'd1, 4'd4, 0, k);
    check("t4_wrap_last", 32'(last_hs_cyc - first_hs_cyc), 32'd3);

    // reset while stalled with a full FIFO
    ready_mode = 3;
    build_model(8'h20, 8'd3, 4'd3, 4'd3);
    clear_sb();
    sb_en = 1;
    launch(8'h20, 8'd3, 4'd3, 4'd3, k);
    repeat (8) @(negedge clk);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_no_read", 32'(mem_rd_en), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_issued", 32'(issued), 32'd2);
    sb_en = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_outs", 32'({mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done}), 32'd0);
    reset = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    check("rst_after_outs", 32'({mem_rd_en, out_valid, busy, done}), 32'd0);
    drain(8'h33, 8'd1, 4'd1, 4'd1, 0, k);

    // negative element clamping
    mem_model[8'h40] = 16'hFFF0;
    mem_model[8'h41] = 16'h0007;
    drain(8'h40, 8'd1, 4'd1, 4'd2, 0, k);
    check("relu_e0", 32'(got_q[0]), 32'(RELU_EXP0));
    check("relu_e1", 32'(got_q[1]), 32'h0007);

    // randomized matrices with random backpressure and ignored restarts
    ready_mode = 2;
    for (int it = 0; it < 8; it++) begin
      logic [7:0] b;
      logic [7:0] s;
      logic [3:0] nr;
      logic [3:0] nc;
      b  = 8'($urandom);
      s  = 8'($urandom_range(0, 12));
      nr = 4'($urandom_range(1, 4));
      nc = 4'($urandom_range(1, 5));
      drain(b, s, nr, nc, (int'(nr) * int'(nc) >= 4), k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
